subbytes_serial: RTL and testbench
==================================

# subbytes_serial

Iterative AES SubBytes / InvSubBytes engine for a full 128-bit state. Accepts one state over a valid/ready handshake and substitutes all 16 bytes using `BYTES_PER_CYCLE` combined forward/inverse S-box instances, one slice per cycle. Returns the result over a second valid/ready handshake. Sits between the round datapath registers and the S-box layer, so one block serves both cipher and inverse-cipher rounds.

## Interface
- `BYTES_PER_CYCLE`, default 1: bytes substituted per RUN cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_state` and `in_encrypt` are valid.
- `in_ready` output 1: engine can accept a state.
- `in_state` input 128: state to substitute; byte i = `in_state[8i+7:8i]`.
- `in_encrypt` input 1: 1 selects SubBytes (forward S-box); 0 selects InvSubBytes.
- `out_valid` output 1: `out_state` holds a finished result.
- `out_ready` input 1: downstream accepts the result.
- `out_state` output 128: substituted state, same byte ordering as `in_state`.

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset forces IDLE, with the byte counter, state register and mode register all cleared.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch `in_state` into the state register and `in_encrypt` into the mode register, clear the counter, and go to RUN.
- RUN, per cycle:
  - Bytes `cnt*BYTES_PER_CYCLE` through `cnt*BYTES_PER_CYCLE + BYTES_PER_CYCLE - 1` pass through the S-box instances, using the latched mode.
  - The results overwrite those same bytes in the state register, and `cnt` increments.
  - When `cnt` reaches `16/BYTES_PER_CYCLE - 1`, the last slice is written and the FSM goes to DONE.
  - `cnt` width is `max(1, $clog2(16/BYTES_PER_CYCLE))`.
- DONE:
  - `out_valid` = 1 and `out_state` = state register.
  - On `out_ready`, go to IDLE.
- Bytes are processed in ascending index order.
- The S-box is purely combinational: each slice is read and written back in the same cycle.
- Input changes outside the accept cycle have no effect, including `in_encrypt` changing mid-RUN.
- `out_state` is stable while `out_valid` = 1.
- `in_ready` is 0 in RUN and DONE. There is no overlap of input acceptance and output delivery.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_state` = 0.
- Latency:
  - Accept edge at cycle 0. RUN occupies cycles 1 through N, where N = 16/`BYTES_PER_CYCLE`.
  - `out_valid` rises after the edge ending cycle N, i.e. it is visible in cycle N+1.
  - With `BYTES_PER_CYCLE` = 1, this is 17 cycles from accept to `out_valid`.
- Throughput: with `out_ready` held high, one state per N+2 cycles. `in_ready` returns in the cycle after the output handshake.
- Backpressure: DONE is held indefinitely while `out_ready` = 0.
- `out_ready` asserted while `out_valid` = 0 is ignored.
- Reset during RUN or DONE:
  - The in-flight state is discarded and no `out_valid` pulse is produced.
  - The next cycle is IDLE with reset values.
- Reset has priority over a simultaneous `in_valid` or `out_ready`.

## Structure
- Shared package `subbytes_pkg` holds:
  - `AES_STATE_W` = 128 and `AES_NUM_BYTES` = 16.
  - The FSM enum type `subbytes_state_t` {IDLE, RUN, DONE}.
  - A `byte_t` typedef.
- Sub-module: the existing combined forward/inverse S-box (`sbox_canright`), instantiated `BYTES_PER_CYCLE` times through a generate loop. The shared mode register drives its `encrypt` input.
- Slice selection uses indexed part-select on `cnt`. No other sub-modules.

## Test plan
- Forward, `BYTES_PER_CYCLE` = 1: all-zero state, `in_encrypt` = 1 → `out_state` = 0x6363…63, with `out_valid` first high exactly 17 cycles after the accept edge.
- Forward, incrementing bytes: byte i = i (i = 0..15) → byte 0 = 0x63, byte 1 = 0x7C, byte 2 = 0x77, byte 15 = 0x76. Repeat for `BYTES_PER_CYCLE` = 1, 4 and 16 and check latencies of 17, 5 and 2 cycles respectively.
- Inverse: all bytes 0x63, `in_encrypt` = 0 → all 0x00. All bytes 0x00, `in_encrypt` = 0 → all 0x52.
- Round trip: 1000 random states, each run forward then the result run inverse → every final state equals its original. `in_encrypt` is toggled randomly during RUN and has no effect.
- Backpressure: hold `out_ready` = 0 for 20 cycles after `out_valid` → `out_state` stable, `in_ready` = 0, and `in_valid` pulses are ignored. Releasing gives exactly one output handshake, then `in_ready` = 1 on the next cycle.
- Reset mid-RUN at cycle 8, then reset during DONE → `out_valid` never asserted for the aborted state, and `in_ready` = 1 in the cycle after reset. A following all-zero forward request yields 0x63…63.

Source files
------------

// File: rtl/subbytes_pkg.sv
// Shared types and constants for the iterative SubBytes / InvSubBytes engine.
package subbytes_pkg;
    localparam int AES_STATE_W   = 128;
    localparam int AES_NUM_BYTES = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } subbytes_state_t;
endpackage

// File: rtl/sbox_canright.sv
// Combined forward/inverse AES S-box that shares a single GF(2^8) inversion
// between both directions; only the affine maps are direction specific.
module sbox_canright
    import subbytes_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_encrypt,
    output logic [7:0] o_byte
);
    function automatic byte_t gf_mul(byte_t a, byte_t b);
        byte_t p = 8'h00;
        byte_t x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 gives the multiplicative inverse and maps 0 to 0
    function automatic byte_t gf_inv(byte_t a);
        byte_t sq = a;
        byte_t r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic byte_t rotl(byte_t x, int n);
        return byte_t'((x << n) | (x >> (8 - n)));
    endfunction

    byte_t w_inv_in;
    byte_t w_inv_out;
    byte_t w_fwd_aff;
    byte_t w_inv_aff;

    always_comb begin
        w_inv_aff = rotl(i_byte, 1) ^ rotl(i_byte, 3) ^ rotl(i_byte, 6) ^ 8'h05;
        w_inv_in  = i_encrypt ? i_byte : w_inv_aff;
        w_inv_out = gf_inv(w_inv_in);
        w_fwd_aff = w_inv_out ^ rotl(w_inv_out, 1) ^ rotl(w_inv_out, 2)
                  ^ rotl(w_inv_out, 3) ^ rotl(w_inv_out, 4) ^ 8'h63;
        o_byte    = i_encrypt ? w_fwd_aff : w_inv_out;
    end
endmodule

// File: rtl/subbytes_serial.sv
// Iterative SubBytes / InvSubBytes over a 128-bit state, BYTES_PER_CYCLE bytes
// per cycle in ascending byte order, with valid/ready on both sides.
module subbytes_serial
    import subbytes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_encrypt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);
    localparam int N_SLICES = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam int SLICE_W  = 8 * BYTES_PER_CYCLE;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
        $error("subbytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    subbytes_state_t        r_fsm;
    logic [CNT_W-1:0]       r_cnt;
    logic [AES_STATE_W-1:0] r_state;
    logic                   r_mode;
    logic                   r_in_ready;
    logic                   r_out_valid;

    logic [SLICE_W-1:0]     w_slice_in;
    logic [SLICE_W-1:0]     w_slice_out;
    logic                   w_last;

    assign w_slice_in = r_state[r_cnt * SLICE_W +: SLICE_W];
    assign w_last     = (r_cnt == CNT_W'(N_SLICES - 1));

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        sbox_canright u_sbox (
            .i_byte    (w_slice_in[8*g +: 8]),
            .i_encrypt (r_mode),
            .o_byte    (w_slice_out[8*g +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= IDLE;
            r_cnt       <= '0;
            r_state     <= '0;
            r_mode      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= in_state;
                        r_mode     <= in_encrypt;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_fsm      <= RUN;
                    end
                end
                RUN: begin
                    r_state[r_cnt * SLICE_W +: SLICE_W] <= w_slice_out;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= IDLE;
                    end
                end
                default: begin
                    r_fsm       <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_state;
endmodule

// File: tb/tb_subbytes_serial.sv
// Directed bench for subbytes_serial at BYTES_PER_CYCLE = 1, 4 and 16.
module tb_subbytes_serial;
    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       iv;
    logic [2:0]       ir;
    logic [2:0]       ov;
    logic [127:0]     in_state;
    logic             in_encrypt;
    logic             out_ready;
    logic [2:0][127:0] os;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] ZERO_S  = 128'h0;
    localparam logic [127:0] S63     = {16{8'h63}};
    localparam logic [127:0] S52     = {16{8'h52}};
    localparam logic [127:0] INC_S   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] INC_SUB = 128'h76abd7fe2b670130c56f6bf27b777c63;

    always #5 clk = ~clk;

    subbytes_serial #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_state(in_state), .in_encrypt(in_encrypt), .out_valid(ov[0]),
        .out_ready(out_ready), .out_state(os[0]));

    subbytes_serial #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_state(in_state), .in_encrypt(in_encrypt), .out_valid(ov[1]),
        .out_ready(out_ready), .out_state(os[1]));

    subbytes_serial #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_state(in_state), .in_encrypt(in_encrypt), .out_valid(ov[2]),
        .out_ready(out_ready), .out_state(os[2]));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept on the next edge, then count cycles (accept cycle = 0) until out_valid.
    task automatic start_wait(input int which, input logic [127:0] s, input logic e,
                              output int lat);
        in_state   = s;
        in_encrypt = e;
        iv[which]  = 1'b1;
        @(posedge clk); #1;
        iv  = '0;
        lat = 1;
        while (!ov[which] && lat < 100) begin
            in_encrypt = 1'($urandom_range(0, 1));
            in_state   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic xact(input int which, input logic [127:0] s, input logic e,
                        output logic [127:0] res, output int lat);
        out_ready = 1'b1;
        start_wait(which, s, e, lat);
        res = os[which];
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] mid;
        logic [127:0] orig;
        logic [127:0] held;
        int           lat;
        int           rt_bad;
        logic         bp_ok;
        logic         seen;

        reset = 1'b1; iv = '0; in_state = '0; in_encrypt = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", 128'(ir), 128'h7);
        check("rst_out_valid", 128'(ov), 128'h0);
        check("rst_out_state", os[0], ZERO_S);

        xact(0, ZERO_S, 1'b1, res, lat);
        check("fwd_zero", res, S63);
        check("fwd_zero_lat", 128'(lat), 128'd17);
        check("in_ready_after_hs", 128'(ir[0]), 128'h1);

        xact(0, INC_S, 1'b1, res, lat);
        check("fwd_inc_b1", res, INC_SUB);
        check("lat_b1", 128'(lat), 128'd17);
        xact(1, INC_S, 1'b1, res, lat);
        check("fwd_inc_b4", res, INC_SUB);
        check("lat_b4", 128'(lat), 128'd5);
        xact(2, INC_S, 1'b1, res, lat);
        check("fwd_inc_b16", res, INC_SUB);
        check("lat_b16", 128'(lat), 128'd2);

        xact(0, S63, 1'b0, res, lat);
        check("inv_63", res, ZERO_S);
        xact(0, ZERO_S, 1'b0, res, lat);
        check("inv_00", res, S52);
        xact(2, ZERO_S, 1'b0, res, lat);
        check("inv_00_b16", res, S52);

        rt_bad = 0;
        for (int k = 0; k < 1000; k++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            xact(0, orig, 1'b1, mid, lat);
            xact(0, mid, 1'b0, res, lat);
            check("round_trip", res, orig);
        end

        out_ready = 1'b0;
        start_wait(0, INC_S, 1'b1, lat);
        check("bp_valid_seen", 128'(ov[0]), 128'h1);
        held  = os[0];
        bp_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            iv[0]    = 1'(k % 2);
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            if (os[0] !== held || ir[0] !== 1'b0 || ov[0] !== 1'b1) bp_ok = 1'b0;
        end
        iv = '0;
        check("bp_hold", 128'(bp_ok), 128'h1);
        check("bp_result", held, INC_SUB);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 128'(ov[0]), 128'h0);
        check("bp_release_ready", 128'(ir[0]), 128'h1);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        check("bp_single_hs", 128'(seen), 128'h0);

        in_state = S63; in_encrypt = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv = '0;
        repeat (7) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_run_ready", 128'(ir[0]), 128'h1);
        check("rst_run_valid", 128'(ov[0]), 128'h0);
        check("rst_run_state", os[0], ZERO_S);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        check("rst_run_no_out", 128'(seen), 128'h0);

        out_ready = 1'b0;
        start_wait(0, S63, 1'b1, lat);
        check("rst_done_reached", 128'(ov[0]), 128'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_done_ready", 128'(ir[0]), 128'h1);
        check("rst_done_valid", 128'(ov[0]), 128'h0);
        check("rst_done_state", os[0], ZERO_S);

        xact(0, ZERO_S, 1'b1, res, lat);
        check("post_rst_fwd", res, S63);
        check("post_rst_lat", 128'(lat), 128'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
